// File: rtl/fp_wb_stage.sv
// fp_wb_stage: FP result writeback buffer. Results from the FPU are NaN-boxed
// (singles) and queued in a small FIFO ahead of the FP register file, and the
// exception flags of each retired entry are ORed into a sticky fflags register.
// Optional build macro FP_WB_CANON_NAN_EN: when defined, NaN results are
// replaced by the canonical quiet NaN of their format before being queued.
module fp_wb_stage #(
  parameter int BUS_WIDTH = 64,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_fmt,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [4:0]           out_rd,
  input  logic                 fflags_clr,
  output logic [4:0]           fflags
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [BUS_WIDTH-1:0] data_mem  [DEPTH];
  logic [4:0]           rd_mem    [DEPTH];
  logic [4:0]           flags_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Format a raw FPU result for the register file: NaN-box singles, and
  // optionally canonicalise NaNs.
  function automatic logic [BUS_WIDTH-1:0] wb_format(
    input logic [BUS_WIDTH-1:0] d,
    input logic                 fmt
  );
    logic [BUS_WIDTH-1:0] r;
    if (fmt) begin
      r = d;
`ifdef FP_WB_CANON_NAN_EN
      if (d[62:52] == 11'h7FF && d[51:0] != 52'd0)
        r = 64'h7FF8_0000_0000_0000;
`endif
    end else begin
      r = {32'hFFFF_FFFF, d[31:0]};
`ifdef FP_WB_CANON_NAN_EN
      if (d[30:23] == 8'hFF && d[22:0] != 23'd0)
        r = 64'hFFFF_FFFF_7FC0_0000;
`endif
    end
    return r;
  endfunction

  // Handshake decode; readiness depends only on registered occupancy.
  always_comb begin
    in_ready  = (count != FULL);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Head entry is presented only while valid, so outputs read 0 out of reset.
  always_comb begin
    out_data = '0;
    out_rd   = '0;
    if (out_valid) begin
      out_data = data_mem[rd_ptr];
      out_rd   = rd_mem[rd_ptr];
    end
  end

  // Entry storage; written only on push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= wb_format(in_data, in_fmt);
      rd_mem[wr_ptr]    <= in_rd;
      flags_mem[wr_ptr] <= in_flags;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a retiring entry wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= '0;
    end else if (pop) begin
      fflags <= fflags_clr ? flags_mem[rd_ptr] : (fflags | flags_mem[rd_ptr]);
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end

endmodule

// File: tb/tb_fp_wb_stage.sv
// tb_fp_wb_stage: directed bench for fp_wb_stage (DEPTH=2).
module tb_fp_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_fmt;
  logic [4:0]  in_rd;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        fflags_clr;
  logic [4:0]  fflags;

  int nvec = 0;
  int nerr = 0;

  fp_wb_stage #(.BUS_WIDTH(64), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .fflags_clr(fflags_clr), .fflags(fflags)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic f, input logic [4:0] r,
                       input logic [4:0] fl);
    in_valid = 1'b1; in_data = d; in_fmt = f; in_rd = r; in_flags = fl;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = 64'hDEAD_BEEF_DEAD_BEEF; in_fmt = 1'b1;
    in_rd = 5'd31; in_flags = 5'b11111;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); out_ready = 1'b0; fflags_clr = 1'b0;
    step(); step();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    nvec++; if (fflags !== 5'd0) begin nerr++; $display("FAIL reset_fflags got %b exp 0", fflags); end
    nvec++; if (out_data !== 64'd0 || out_rd !== 5'd0) begin nerr++;
      $display("FAIL reset_out_data got %h/%0d exp 0/0", out_data, out_rd); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(64'h0000_0000_3F80_0000, 1'b0, 5'd3, 5'd0);
    step(); idle();
    nvec++; if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_3F80_0000 || out_rd !== 5'd3) begin
      nerr++; $display("FAIL single_box got v=%b %h rd=%0d exp v=1 ffffffff3f800000 rd=3", out_valid, out_data, out_rd); end
    step();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_double();
    out_ready = 1'b1;
    drive(64'h4009_21FB_5444_2D18, 1'b1, 5'd7, 5'd0);
    step(); idle();
    nvec++; if (out_data !== 64'h4009_21FB_5444_2D18 || out_rd !== 5'd7) begin
      nerr++; $display("FAIL double_pass got %h rd=%0d exp 400921fb54442d18 rd=7", out_data, out_rd); end
    step();
  endtask

  task automatic test_ignore();
    out_ready = 1'b0; idle();
    step(); step();
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL ignore_idle got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(64'h0000_0000_0000_0011, 1'b0, 5'd1, 5'd0); step();
    drive(64'h0000_0000_0000_0022, 1'b0, 5'd2, 5'd0); step();
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    drive(64'h0000_0000_0000_0033, 1'b0, 5'd3, 5'd0); step(); idle();
    nvec++; if (out_rd !== 5'd1 || out_data !== 64'hFFFF_FFFF_0000_0011) begin
      nerr++; $display("FAIL bp_hold got %h rd=%0d exp ffffffff00000011 rd=1", out_data, out_rd); end
    out_ready = 1'b1; step();
    nvec++; if (out_rd !== 5'd2 || out_data !== 64'hFFFF_FFFF_0000_0022) begin
      nerr++; $display("FAIL bp_order got %h rd=%0d exp ffffffff00000022 rd=2", out_data, out_rd); end
    step();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_third_dropped got %b exp 0", out_valid); end
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0;
    drive(64'd4, 1'b1, 5'd4, 5'd0); step();
    drive(64'd5, 1'b1, 5'd5, 5'd0); step();
    drive(64'd6, 1'b1, 5'd6, 5'd0); out_ready = 1'b1; step();
    idle(); out_ready = 1'b0;
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd5) begin
      nerr++; $display("FAIL full_pop_only got r=%b v=%b rd=%0d exp r=1 v=1 rd=5", in_ready, out_valid, out_rd); end
    out_ready = 1'b1; step();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL full_count1 got %b exp 0", out_valid); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1; fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    nvec++; if (fflags !== 5'd0) begin nerr++; $display("FAIL flags_clr0 got %b exp 00000", fflags); end
    drive(64'd1, 1'b0, 5'd8, 5'b00001); step(); idle(); step();
    nvec++; if (fflags !== 5'b00001) begin nerr++; $display("FAIL flags_first got %b exp 00001", fflags); end
    drive(64'd2, 1'b0, 5'd9, 5'b10000); step(); idle(); step();
    nvec++; if (fflags !== 5'b10001) begin nerr++; $display("FAIL flags_accum got %b exp 10001", fflags); end
    drive(64'd3, 1'b0, 5'd10, 5'b00100); step(); idle();
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    nvec++; if (fflags !== 5'b00100) begin nerr++; $display("FAIL flags_clr_pop got %b exp 00100", fflags); end
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    nvec++; if (fflags !== 5'd0) begin nerr++; $display("FAIL flags_clr_only got %b exp 00000", fflags); end
  endtask

  task automatic test_nan();
    logic [63:0] exp_s;
    logic [63:0] exp_d;
`ifdef FP_WB_CANON_NAN_EN
    exp_s = 64'hFFFF_FFFF_7FC0_0000;
    exp_d = 64'h7FF8_0000_0000_0000;
`else
    exp_s = 64'hFFFF_FFFF_7F80_0001;
    exp_d = 64'h7FF0_0000_0000_0001;
`endif
    out_ready = 1'b1;
    drive(64'h0000_0000_7F80_0001, 1'b0, 5'd11, 5'd0); step(); idle();
    nvec++; if (out_data !== exp_s) begin nerr++; $display("FAIL nan_single got %h exp %h", out_data, exp_s); end
    step();
    drive(64'h7FF0_0000_0000_0001, 1'b1, 5'd12, 5'd0); step(); idle();
    nvec++; if (out_data !== exp_d) begin nerr++; $display("FAIL nan_double got %h exp %h", out_data, exp_d); end
    step();
    drive(64'h0000_0000_7F80_0000, 1'b0, 5'd13, 5'd0); step(); idle();
    nvec++; if (out_data !== 64'hFFFF_FFFF_7F80_0000) begin
      nerr++; $display("FAIL inf_single got %h exp ffffffff7f800000", out_data); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(64'd9, 1'b0, 5'd14, 5'b00010); step(); idle(); step();
    nvec++; if (fflags !== 5'b00010) begin nerr++; $display("FAIL ar_pre_flags got %b exp 00010", fflags); end
    out_ready = 1'b0;
    drive(64'd10, 1'b0, 5'd15, 5'b11111); step();
    drive(64'd11, 1'b0, 5'd16, 5'b11111); step(); idle();
    #2 rst = 1'b1;
    #1;
    nvec++; if (out_valid !== 1'b0 || fflags !== 5'd0 || in_ready !== 1'b1 || out_data !== 64'd0) begin
      nerr++; $display("FAIL async_reset got v=%b f=%b r=%b d=%h exp v=0 f=0 r=1 d=0",
                       out_valid, fflags, in_ready, out_data); end
    step(); rst = 1'b0; out_ready = 1'b1; step();
    nvec++; if (out_valid !== 1'b0 || fflags !== 5'd0) begin
      nerr++; $display("FAIL ar_discard got v=%b f=%b exp v=0 f=00000", out_valid, fflags); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_ignore();
    test_backpressure();
    test_full_simul();
    test_flags();
    test_nan();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
